// File: rtl/dmem_arb_pkg.sv
// Shared types and constants for the MEM-stage data-port arbiter.
// The IO region is selected by address bit IO_SEL_BIT; RAM words are indexed by addr[6:2].
package dmem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE,
        EXT_GRANT,
        EXT_DONE
    } arb_state_t;

    localparam int unsigned IO_SEL_BIT  = 7;
    localparam int unsigned RAM_IDX_LSB = 2;
    localparam int unsigned RAM_IDX_MSB = 6;

endpackage

// File: rtl/dmem_arbiter_if.sv
// Bundle of CPU, external-requester and memory-port signals around the data-port arbiter.
// slave is the arbiter's view; master is the surrounding pipeline/requester/memory.
interface dmem_arbiter_if #(
    parameter int unsigned AW = 32
);
    logic          cpu_req;
    logic          cpu_we;
    logic [AW-1:0] cpu_addr;
    logic [31:0]   cpu_wdata;
    logic [31:0]   cpu_rdata;
    logic          cpu_stall;

    logic          ext_req;
    logic          ext_we;
    logic [AW-1:0] ext_addr;
    logic [31:0]   ext_wdata;
    logic          ext_ack;
    logic [31:0]   ext_rdata;
    logic          ext_err;

    logic [AW-1:0] mem_addr;
    logic [31:0]   mem_wdata;
    logic          mem_we;
    logic [31:0]   mem_rdata;

    modport slave (
        input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
        output cpu_rdata, cpu_stall,
        input  ext_req, ext_we, ext_addr, ext_wdata,
        output ext_ack, ext_rdata, ext_err,
        output mem_addr, mem_wdata, mem_we,
        input  mem_rdata
    );

    modport master (
        output cpu_req, cpu_we, cpu_addr, cpu_wdata,
        input  cpu_rdata, cpu_stall,
        output ext_req, ext_we, ext_addr, ext_wdata,
        input  ext_ack, ext_rdata, ext_err,
        input  mem_addr, mem_wdata, mem_we,
        output mem_rdata
    );

endinterface

// File: rtl/arb_starve_counter.sv
// Counts consecutive cycles the external requester was denied; saturates at LIMIT-1.
// limit_hit_o flags that one more denial must force the external grant.
module arb_starve_counter #(
    parameter int unsigned LIMIT = 8
) (
    input  logic clock,
    input  logic reset,
    input  logic inc_i,
    input  logic clear_i,
    output logic limit_hit_o
);

    localparam int unsigned   CW      = $clog2(LIMIT + 1);
    localparam logic [CW-1:0] CNT_MAX = CW'(LIMIT - 1);

    logic [CW-1:0] count_q;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            count_q <= '0;
        end else if (clear_i) begin
            count_q <= '0;
        end else if (inc_i && (count_q != CNT_MAX)) begin
            count_q <= count_q + 1'b1;
        end
    end

    assign limit_hit_o = (count_q == CNT_MAX);

endmodule

// File: rtl/dmem_arbiter.sv
// Shares the MEM-stage data port between the CPU (priority) and one external requester.
// Define DMEM_ARB_EXT_IO_EN to let the external requester reach the IO region (addr[7]=1).
module dmem_arbiter #(
    parameter int unsigned STARVE_LIMIT = 8,
    parameter int unsigned AW           = 32
) (
    input logic           clock,
    input logic           reset,
    dmem_arbiter_if.slave bus
);
    import dmem_arb_pkg::*;

    arb_state_t  state;
    logic        ext_ack_q;
    logic        ext_err_q;
    logic [31:0] ext_rdata_q;

    logic ext_io;
    logic starve_hit;
    logic denied;
    logic grant_go;

`ifdef DMEM_ARB_EXT_IO_EN
    assign ext_io = 1'b0;
`else
    // IO accesses from the requester are refused but still run the full handshake.
    assign ext_io = bus.ext_addr[IO_SEL_BIT];
`endif

    // Only a denial in IDLE counts; any other cycle restarts the starvation window.
    assign denied   = (state == IDLE) && bus.ext_req && bus.cpu_req;
    assign grant_go = (state == IDLE) && bus.ext_req && (!bus.cpu_req || starve_hit);

    arb_starve_counter #(
        .LIMIT (STARVE_LIMIT)
    ) u_starve (
        .clock       (clock),
        .reset       (reset),
        .inc_i       (denied),
        .clear_i     (!denied),
        .limit_hit_o (starve_hit)
    );

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            ext_ack_q   <= 1'b0;
            ext_err_q   <= 1'b0;
            ext_rdata_q <= '0;
        end else begin
            ext_ack_q <= 1'b0;
            ext_err_q <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (grant_go) begin
                        state <= EXT_GRANT;
                    end
                end
                EXT_GRANT: begin
                    state       <= EXT_DONE;
                    ext_ack_q   <= 1'b1;
                    ext_err_q   <= ext_io;
                    ext_rdata_q <= ext_io ? '0 : bus.mem_rdata;
                end
                EXT_DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    always_comb begin
        bus.mem_addr  = bus.cpu_addr;
        bus.mem_wdata = bus.cpu_wdata;
        bus.mem_we    = bus.cpu_req && bus.cpu_we && !reset;
        bus.cpu_stall = 1'b0;
        if (state == EXT_GRANT) begin
            bus.mem_addr  = bus.ext_addr;
            bus.mem_wdata = bus.ext_wdata;
            bus.mem_we    = bus.ext_we && !ext_io && !reset;
            bus.cpu_stall = bus.cpu_req;
        end
    end

    assign bus.cpu_rdata = bus.mem_rdata;
    assign bus.ext_ack   = ext_ack_q;
    assign bus.ext_err   = ext_err_q;
    assign bus.ext_rdata = ext_rdata_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Self-checking bench for dmem_arbiter: directed scenarios plus a randomized run against
// a timeline/memory reference model.
module tb_dmem_arbiter;

    localparam int unsigned L  = 8;
    localparam int unsigned AW = 32;
`ifdef DMEM_ARB_EXT_IO_EN
    localparam bit IO_EN = 1'b1;
`else
    localparam bit IO_EN = 1'b0;
`endif

    logic clock;
    logic reset;

    int vectors     = 0;
    int miscompares = 0;

    logic [31:0] ref_mem [64];
    logic [31:0] dev_mem [64];

    dmem_arbiter_if #(.AW(AW)) bus ();

    dmem_arbiter #(
        .STARVE_LIMIT (L),
        .AW           (AW)
    ) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    // Memory device behind the port: combinational read, write on the rising edge.
    always @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < 64; i++) dev_mem[i] <= '0;
        end else if (bus.mem_we) begin
            dev_mem[bus.mem_addr[7:2]] <= bus.mem_wdata;
        end
    end
    assign bus.mem_rdata = dev_mem[bus.mem_addr[7:2]];

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic idle_inputs();
        bus.cpu_req   = 1'b0;
        bus.cpu_we    = 1'b0;
        bus.cpu_addr  = '0;
        bus.cpu_wdata = '0;
        bus.ext_req   = 1'b0;
        bus.ext_we    = 1'b0;
        bus.ext_addr  = '0;
        bus.ext_wdata = '0;
    endtask

    task automatic next_cycle();
        @(posedge clock);
        #1;
    endtask

    task automatic clear_ref();
        for (int i = 0; i < 64; i++) ref_mem[i] = '0;
    endtask

    task automatic set_ext(input logic we, input logic [31:0] addr, input logic [31:0] wd);
        bus.ext_req   = 1'b1;
        bus.ext_we    = we;
        bus.ext_addr  = addr;
        bus.ext_wdata = wd;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        idle_inputs();
        bus.cpu_req = 1'b1;
        bus.cpu_we  = 1'b1;
        repeat (2) @(posedge clock);
        #3;
        vectors++;
        if (bus.ext_ack !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_ext_ack: got %b want 0", bus.ext_ack);
        end
        vectors++;
        if (bus.ext_err !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_ext_err: got %b want 0", bus.ext_err);
        end
        vectors++;
        if (bus.ext_rdata !== 32'h0) begin
            miscompares++;
            $display("FAIL reset_ext_rdata: got %h want 0", bus.ext_rdata);
        end
        vectors++;
        if (bus.cpu_stall !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_cpu_stall: got %b want 0", bus.cpu_stall);
        end
        vectors++;
        if (bus.mem_we !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_mem_we: got %b want 0", bus.mem_we);
        end
        clear_ref();
        @(posedge clock);
        #1;
        reset = 1'b0;
        idle_inputs();
    endtask

    task automatic test_cpu_only();
        bus.cpu_req = 1'b1; bus.cpu_we = 1'b1; bus.cpu_addr = 32'h08; bus.cpu_wdata = 32'h5A;
        #3;
        vectors++;
        if (bus.mem_we !== 1'b1 || bus.cpu_stall !== 1'b0) begin
            miscompares++;
            $display("FAIL cpu_sw: mem_we=%b stall=%b want 1/0", bus.mem_we, bus.cpu_stall);
        end
        next_cycle();
        ref_mem[2] = 32'h5A;
        bus.cpu_we = 1'b0;
        #3;
        vectors++;
        if (bus.cpu_rdata !== 32'h5A || bus.mem_we !== 1'b0) begin
            miscompares++;
            $display("FAIL cpu_lw: rdata=%h mem_we=%b want 5a/0", bus.cpu_rdata, bus.mem_we);
        end
        next_cycle();
        for (int n = 0; n < 24; n++) begin
            int idx = $urandom_range(0, 31);
            logic req = 1'($urandom_range(0, 1));
            logic we  = 1'($urandom_range(0, 1));
            logic [31:0] wd = $urandom;
            bus.cpu_req = req; bus.cpu_we = we; bus.cpu_addr = 32'(idx) << 2; bus.cpu_wdata = wd;
            #3;
            vectors++;
            if (bus.mem_we !== (req && we) || bus.cpu_stall !== 1'b0) begin
                miscompares++;
                $display("FAIL cpu_rand_we: mem_we=%b stall=%b want %b/0",
                         bus.mem_we, bus.cpu_stall, req && we);
            end
            if (req && !we) begin
                vectors++;
                if (bus.cpu_rdata !== ref_mem[idx]) begin
                    miscompares++;
                    $display("FAIL cpu_rand_rd: got %h want %h", bus.cpu_rdata, ref_mem[idx]);
                end
            end
            next_cycle();
            if (req && we) ref_mem[idx] = wd;
        end
        idle_inputs();
        next_cycle();
    endtask

    task automatic test_ext_idle();
        set_ext(1'b1, 32'h10, 32'h1234);
        #3;
        vectors++;
        if (bus.ext_ack !== 1'b0) begin
            miscompares++;
            $display("FAIL ext_c0_ack: got %b want 0", bus.ext_ack);
        end
        next_cycle();
        #3;
        vectors++;
        if (bus.mem_we !== 1'b1 || bus.mem_addr !== 32'h10 || bus.cpu_stall !== 1'b0) begin
            miscompares++;
            $display("FAIL ext_grant: we=%b addr=%h stall=%b want 1/10/0",
                     bus.mem_we, bus.mem_addr, bus.cpu_stall);
        end
        next_cycle();
        ref_mem[4] = 32'h1234;
        #3;
        vectors++;
        if (bus.ext_ack !== 1'b1 || bus.ext_err !== 1'b0) begin
            miscompares++;
            $display("FAIL ext_ack: ack=%b err=%b want 1/0", bus.ext_ack, bus.ext_err);
        end
        next_cycle();
        idle_inputs();
        bus.cpu_req = 1'b1; bus.cpu_addr = 32'h10;
        #3;
        vectors++;
        if (bus.cpu_rdata !== 32'h1234 || bus.ext_ack !== 1'b0) begin
            miscompares++;
            $display("FAIL ext_then_lw: rdata=%h ack=%b want 1234/0", bus.cpu_rdata, bus.ext_ack);
        end
        next_cycle();
        idle_inputs();
        set_ext(1'b0, 32'h08, 32'h0);
        next_cycle();
        next_cycle();
        #3;
        vectors++;
        if (bus.ext_ack !== 1'b1 || bus.ext_rdata !== ref_mem[2]) begin
            miscompares++;
            $display("FAIL ext_read: ack=%b rdata=%h want 1/%h", bus.ext_ack, bus.ext_rdata,
                     ref_mem[2]);
        end
        next_cycle();
        idle_inputs();
        #3;
        vectors++;
        if (bus.ext_ack !== 1'b0 || bus.ext_rdata !== ref_mem[2]) begin
            miscompares++;
            $display("FAIL ext_rdata_hold: ack=%b rdata=%h want 0/%h", bus.ext_ack,
                     bus.ext_rdata, ref_mem[2]);
        end
        next_cycle();
    endtask

    task automatic test_starve();
        logic [31:0] wd = $urandom;
        int stalls = 0;
        for (int t = 0; t <= int'(L) + 1; t++) begin
            int idx = $urandom_range(0, 31);
            set_ext(1'b1, 32'h1C, wd);
            bus.cpu_req = 1'b1; bus.cpu_we = 1'b0; bus.cpu_addr = 32'(idx) << 2;
            #3;
            if (bus.cpu_stall === 1'b1) stalls++;
            vectors++;
            if (bus.cpu_stall !== (t == int'(L)) || bus.ext_ack !== (t == int'(L) + 1)) begin
                miscompares++;
                $display("FAIL starve_t%0d: stall=%b ack=%b want %b/%b", t, bus.cpu_stall,
                         bus.ext_ack, t == int'(L), t == int'(L) + 1);
            end
            if (t == int'(L)) begin
                vectors++;
                if (bus.mem_we !== 1'b1 || bus.mem_addr !== 32'h1C) begin
                    miscompares++;
                    $display("FAIL starve_grant_port: we=%b addr=%h want 1/1c", bus.mem_we,
                             bus.mem_addr);
                end
            end else begin
                vectors++;
                if (bus.cpu_rdata !== ref_mem[idx]) begin
                    miscompares++;
                    $display("FAIL starve_cpu_rd: got %h want %h", bus.cpu_rdata, ref_mem[idx]);
                end
            end
            next_cycle();
            if (t == int'(L)) ref_mem[7] = wd;
        end
        idle_inputs();
        vectors++;
        if (stalls != 1) begin
            miscompares++;
            $display("FAIL starve_stall_count: got %0d want 1", stalls);
        end
        next_cycle();
    endtask

    task automatic test_hold_req();
        int acks = 0;
        for (int t = 0; t < 9; t++) begin
            set_ext(1'b0, 32'h04, 32'h0);
            #3;
            if (bus.ext_ack === 1'b1) acks++;
            vectors++;
            if (bus.ext_ack !== ((t % 3) == 2)) begin
                miscompares++;
                $display("FAIL hold_t%0d: ack=%b want %b", t, bus.ext_ack, (t % 3) == 2);
            end
            next_cycle();
        end
        idle_inputs();
        vectors++;
        if (acks != 3) begin
            miscompares++;
            $display("FAIL hold_ack_count: got %0d want 3", acks);
        end
        next_cycle();
    endtask

    task automatic test_io();
        bus.cpu_req = 1'b1; bus.cpu_we = 1'b1; bus.cpu_addr = 32'h80; bus.cpu_wdata = 32'hCAFE0000;
        #3;
        vectors++;
        if (bus.mem_we !== 1'b1) begin
            miscompares++;
            $display("FAIL io_cpu_sw: mem_we=%b want 1", bus.mem_we);
        end
        next_cycle();
        ref_mem[32] = 32'hCAFE0000;
        idle_inputs();
        set_ext(1'b1, 32'h80, 32'h0000BEEF);
        next_cycle();
        #3;
        vectors++;
        if (bus.mem_we !== IO_EN) begin
            miscompares++;
            $display("FAIL io_ext_we: mem_we=%b want %b", bus.mem_we, IO_EN);
        end
        next_cycle();
        if (IO_EN) ref_mem[32] = 32'h0000BEEF;
        #3;
        vectors++;
        if (bus.ext_ack !== 1'b1 || bus.ext_err !== !IO_EN) begin
            miscompares++;
            $display("FAIL io_ext_wr_ack: ack=%b err=%b want 1/%b", bus.ext_ack, bus.ext_err,
                     !IO_EN);
        end
        next_cycle();
        idle_inputs();
        set_ext(1'b0, 32'h80, 32'h0);
        next_cycle();
        next_cycle();
        #3;
        vectors++;
        if (bus.ext_ack !== 1'b1 || bus.ext_err !== !IO_EN ||
            bus.ext_rdata !== (IO_EN ? ref_mem[32] : 32'h0)) begin
            miscompares++;
            $display("FAIL io_ext_rd: ack=%b err=%b rdata=%h want 1/%b/%h", bus.ext_ack,
                     bus.ext_err, bus.ext_rdata, !IO_EN, IO_EN ? ref_mem[32] : 32'h0);
        end
        next_cycle();
        idle_inputs();
        bus.cpu_req = 1'b1; bus.cpu_addr = 32'h80;
        #3;
        vectors++;
        if (bus.cpu_rdata !== ref_mem[32]) begin
            miscompares++;
            $display("FAIL io_cpu_lw: got %h want %h", bus.cpu_rdata, ref_mem[32]);
        end
        next_cycle();
        idle_inputs();
        next_cycle();
    endtask

    task automatic test_reset_mid_grant();
        set_ext(1'b1, 32'h20, 32'h55AA55AA);
        next_cycle();
        reset = 1'b1;
        bus.cpu_req = 1'b1;
        #3;
        vectors++;
        if (bus.ext_ack !== 1'b0 || bus.cpu_stall !== 1'b0 || bus.mem_we !== 1'b0) begin
            miscompares++;
            $display("FAIL rst_grant: ack=%b stall=%b we=%b want 0/0/0", bus.ext_ack,
                     bus.cpu_stall, bus.mem_we);
        end
        next_cycle();
        reset = 1'b0;
        clear_ref();
        idle_inputs();
        for (int t = 0; t < 3; t++) begin
            #3;
            vectors++;
            if (bus.ext_ack !== 1'b0 || bus.cpu_stall !== 1'b0) begin
                miscompares++;
                $display("FAIL rst_after_t%0d: ack=%b stall=%b want 0/0", t, bus.ext_ack,
                         bus.cpu_stall);
            end
            next_cycle();
        end
    endtask

    task automatic test_random();
        for (int it = 0; it < 40; it++) begin
            logic [15:0] pat  = 16'($urandom);
            logic        e_we = 1'($urandom_range(0, 1));
            int          e_idx = $urandom_range(0, 31);
            logic [31:0] e_wd = $urandom;
            logic [31:0] e_rd = '0;
            int          g = 0;
            int          grant_t;
            // Port goes external after the first idle CPU cycle or the L-th denial.
            while (g < int'(L) - 1 && pat[g]) g++;
            grant_t = g + 1;
            for (int t = 0; t <= grant_t + 1; t++) begin
                int          c_idx = $urandom_range(0, 31);
                logic        c_we  = 1'($urandom_range(0, 1));
                logic [31:0] c_wd  = $urandom;
                set_ext(e_we, 32'(e_idx) << 2, e_wd);
                bus.cpu_req = pat[t]; bus.cpu_we = c_we;
                bus.cpu_addr = 32'(c_idx) << 2; bus.cpu_wdata = c_wd;
                #3;
                vectors++;
                if (bus.cpu_stall !== (t == grant_t && pat[t]) ||
                    bus.ext_ack !== (t == grant_t + 1)) begin
                    miscompares++;
                    $display("FAIL rand_%0d_t%0d: stall=%b ack=%b want %b/%b", it, t,
                             bus.cpu_stall, bus.ext_ack, t == grant_t && pat[t],
                             t == grant_t + 1);
                end
                if (t == grant_t) begin
                    e_rd = ref_mem[e_idx];
                    vectors++;
                    if (bus.mem_we !== e_we) begin
                        miscompares++;
                        $display("FAIL rand_grant_we_%0d: got %b want %b", it, bus.mem_we, e_we);
                    end
                end else if (pat[t] && !c_we) begin
                    vectors++;
                    if (bus.cpu_rdata !== ref_mem[c_idx]) begin
                        miscompares++;
                        $display("FAIL rand_cpu_rd_%0d: got %h want %h", it, bus.cpu_rdata,
                                 ref_mem[c_idx]);
                    end
                end
                if (t == grant_t + 1 && !e_we) begin
                    vectors++;
                    if (bus.ext_rdata !== e_rd) begin
                        miscompares++;
                        $display("FAIL rand_ext_rd_%0d: got %h want %h", it, bus.ext_rdata, e_rd);
                    end
                end
                next_cycle();
                if (t == grant_t) begin
                    if (e_we) ref_mem[e_idx] = e_wd;
                end else if (pat[t] && c_we) begin
                    ref_mem[c_idx] = c_wd;
                end
            end
            idle_inputs();
            next_cycle();
        end
    endtask

    initial begin
        test_reset();
        test_cpu_only();
        test_ext_idle();
        test_starve();
        test_hold_req();
        test_io();
        test_reset_mid_grant();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
